// File: rtl/z80_intc.sv
// Vectored IM2 interrupt controller for the tv80n: edge-detected requests, mask, vector base, in-service tracking.
// Optional `INTC_NEST_EN turns in-service into a priority stack so higher-priority sources can preempt.
//
// state | meaning
// IDLE  | no acknowledge cycle in progress, register writes accepted
// ACK   | inta high, latched vector driven on dslave, writes ignored
module z80_intc #(
    parameter int          N_SRC     = 4,
    parameter logic [7:0]  VBASE_RST = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [1:0]       ibus_addr,
    input  logic [7:0]       ibus_dmaster,
    input  logic             ibus_rdn,
    input  logic             ibus_wrn,
    input  logic             ibus_inta,
    output logic [7:0]       obus_dslave,
    output logic             obus_mwait,
    input  logic [N_SRC-1:0] irq,
    output logic             int_n
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t           state, state_nxt;
    logic [N_SRC-1:0] sync1, sync2, sync3, irq_rise;
    logic [N_SRC-1:0] pending, mask, pm, w1c_clr, ack_clr;
    logic [3:0]       vbase;
    logic [2:0]       idx_comb;
    logic [7:0]       vector;
    logic             wrn_prev, wr_stb, ack_start, req;
`ifdef INTC_NEST_EN
    logic [N_SRC-1:0] insvc, ins_lsb, prio_ok;
`else
    logic             insvc;
`endif

    assign obus_mwait = 1'b1;
    assign irq_rise   = sync2 & ~sync3;
    assign pm         = pending & mask;
    assign wr_stb     = ena & ~ibus_wrn & wrn_prev & (state == IDLE);
    assign w1c_clr    = (wr_stb && ibus_addr == 2'd0) ? ibus_dmaster[N_SRC-1:0] : '0;

`ifdef INTC_NEST_EN
    // Only sources strictly below the lowest in-service index may request; empty stack enables all.
    assign ins_lsb = insvc & (~insvc + N_SRC'(1));
    assign prio_ok = ins_lsb - N_SRC'(1);
    assign req     = |(pm & prio_ok);
`else
    assign req     = (|pm) & ~insvc;
`endif

    always_comb begin
        idx_comb = 3'd7;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pm[i]) idx_comb = 3'(i);
        end
    end

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (ack_start && idx_comb == 3'(i)) ack_clr[i] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        ack_start = 1'b0;
        case (state)
            IDLE: if (ibus_inta) begin
                state_nxt = ACK;
                ack_start = 1'b1;
            end
            ACK:  if (!ibus_inta) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sync1    <= '0;
            sync2    <= '0;
            sync3    <= '0;
            pending  <= '0;
            mask     <= '0;
            vbase    <= VBASE_RST[7:4];
            vector   <= 8'h00;
            wrn_prev <= 1'b1;
            int_n    <= 1'b1;
            insvc    <= '0;
        end else begin
            state    <= state_nxt;
            sync1    <= irq;
            sync2    <= sync1;
            sync3    <= sync2;
            wrn_prev <= ibus_wrn;
            int_n    <= ~req;
            // A new edge wins over any clear in the same cycle.
            pending  <= (pending & ~w1c_clr & ~ack_clr) | irq_rise;
            if (wr_stb && ibus_addr == 2'd1) mask  <= ibus_dmaster[N_SRC-1:0];
            if (wr_stb && ibus_addr == 2'd2) vbase <= ibus_dmaster[7:4];
            if (ack_start) vector <= {vbase, idx_comb, 1'b0};
`ifdef INTC_NEST_EN
            if (wr_stb && ibus_addr == 2'd3)
                insvc <= (insvc & ~ins_lsb) | ack_clr;
            else
                insvc <= insvc | ack_clr;
`else
            if (|ack_clr)
                insvc <= 1'b1;
            else if (wr_stb && ibus_addr == 2'd3)
                insvc <= 1'b0;
`endif
        end
    end

    always_comb begin
        obus_dslave = 8'hFF;
        if (state == ACK && ibus_inta) begin
            obus_dslave = vector;
        end else if (ena && !ibus_rdn) begin
            case (ibus_addr)
                2'd0:    obus_dslave = 8'(pending);
                2'd1:    obus_dslave = 8'(mask);
                2'd2:    obus_dslave = {vbase, 4'h0};
                default: obus_dslave = 8'(insvc);
            endcase
        end
    end

endmodule

// File: tb/tb_z80_intc.sv
// Directed bench for z80_intc: expected values queued on a scoreboard as stimulus is applied, popped at each check.
module tb_z80_intc;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b0;
    logic [1:0]   ibus_addr = 2'd0;
    logic [7:0]   ibus_dmaster = 8'h00;
    logic         ibus_rdn = 1'b1;
    logic         ibus_wrn = 1'b1;
    logic         ibus_inta = 1'b0;
    logic [N-1:0] irq = '0;
    logic [7:0]   obus_dslave;
    logic         obus_mwait;
    logic         int_n;

    logic [7:0]   sb[$];
    int           total = 0;
    int           bad = 0;
    logic [7:0]   rdat;

    z80_intc #(.N_SRC(N), .VBASE_RST(8'h5A)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .ibus_addr(ibus_addr), .ibus_dmaster(ibus_dmaster),
        .ibus_rdn(ibus_rdn), .ibus_wrn(ibus_wrn), .ibus_inta(ibus_inta),
        .obus_dslave(obus_dslave), .obus_mwait(obus_mwait),
        .irq(irq), .int_n(int_n)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expv(input logic [7:0] v);
        sb.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        ibus_addr = a;
        ena = 1'b1;
        ibus_rdn = 1'b0;
        #1;
        d = obus_dslave;
        ena = 1'b0;
        ibus_rdn = 1'b1;
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a);
        logic [7:0] d;
        rd(a, d);
        chk(tag, d);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        ibus_addr = a;
        ibus_dmaster = d;
        ena = 1'b1;
        ibus_wrn = 1'b0;
        tick;
        ena = 1'b0;
        ibus_wrn = 1'b1;
        tick;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        irq = m;
        tick;
        irq = '0;
    endtask

    initial begin
        // reset state
        tick; tick;
        rst = 1'b0;
        tick;
        expv(8'h00); chk_rd("rst_pend", 2'd0);
        expv(8'h00); chk_rd("rst_mask", 2'd1);
        expv(8'h50); chk_rd("rst_vbase", 2'd2);
        expv(8'h00); chk_rd("rst_isvc", 2'd3);
        expv(8'h01); chk("rst_int_n", 8'(int_n));
        expv(8'hFF); chk("idle_dslave", obus_dslave);
        expv(8'h01); chk("mwait", 8'(obus_mwait));

        // single source, latency and acknowledge
        wr(2'd1, 8'h0F);
        wr(2'd2, 8'h4C);
        expv(8'h40); chk_rd("vbase_rb", 2'd2);
        expv(8'h00); expv(8'h04); expv(8'h01); expv(8'h00);
        pulse(4'b0100);
        tick;
        chk_rd("pend_clk2", 2'd0);
        tick;
        chk_rd("pend_clk3", 2'd0);
        chk("int_n_clk3", 8'(int_n));
        tick;
        chk("int_n_clk4", 8'(int_n));
        expv(8'h44); expv(8'h44); expv(8'h01); expv(8'h00); expv(8'h01);
        ibus_inta = 1'b1;
        tick;
        chk("vec_irq2", obus_dslave);
        tick;
        chk("vec_hold", obus_dslave);
        chk("int_n_after_ack", 8'(int_n));
        ibus_inta = 1'b0;
        tick;
        chk_rd("pend_after_ack", 2'd0);
        chk_rd("isvc_after_ack", 2'd3);

        // two simultaneous sources, priority and EOI
        wr(2'd3, 8'h00);
        expv(8'h00); expv(8'h42); expv(8'h01); expv(8'h08); expv(8'h00); expv(8'h46); expv(8'h00);
        pulse(4'b1010);
        tick; tick; tick;
        chk("int_n_dual", 8'(int_n));
        ibus_inta = 1'b1;
        tick;
        chk("vec_irq1", obus_dslave);
        ibus_inta = 1'b0;
        tick;
        chk("int_n_in_svc", 8'(int_n));
        chk_rd("pend_irq3_left", 2'd0);
        wr(2'd3, 8'h00);
        chk("int_n_after_eoi", 8'(int_n));
        ibus_inta = 1'b1;
        tick;
        chk("vec_irq3", obus_dslave);
        ibus_inta = 1'b0;
        tick;
        wr(2'd3, 8'h00);
        chk_rd("isvc_cleared", 2'd3);

        // masked source, spurious acknowledge, W1C
        wr(2'd1, 8'h00);
        expv(8'h01); expv(8'h01); expv(8'h4E); expv(8'h00); expv(8'h01); expv(8'h00);
        pulse(4'b0001);
        tick; tick; tick;
        chk_rd("pend_masked", 2'd0);
        chk("int_n_masked", 8'(int_n));
        ibus_inta = 1'b1;
        tick;
        chk("vec_spurious", obus_dslave);
        ibus_inta = 1'b0;
        tick;
        chk_rd("isvc_spurious", 2'd3);
        chk_rd("pend_spurious", 2'd0);
        wr(2'd0, 8'h01);
        chk_rd("pend_w1c", 2'd0);

        // long wrn-low W1C colliding with a new edge on the same bit
        expv(8'h01);
        irq = 4'b0001;
        tick; tick;
        ibus_addr = 2'd0;
        ibus_dmaster = 8'h01;
        ena = 1'b1;
        ibus_wrn = 1'b0;
        repeat (6) tick;
        ena = 1'b0;
        ibus_wrn = 1'b1;
        tick;
        irq = '0;
        chk_rd("pend_set_wins", 2'd0);

        // reset in the middle of an acknowledge
        expv(8'h00); expv(8'h40); expv(8'h01); expv(8'hFF);
        wr(2'd1, 8'h01);
        chk("int_n_pre_rst", 8'(int_n));
        ibus_inta = 1'b1;
        tick;
        chk("vec_pre_rst", obus_dslave);
        #2 rst = 1'b1;
        #1;
        chk("int_n_async_rst", 8'(int_n));
        chk("dslave_async_rst", obus_dslave);
        tick;
        rst = 1'b0;
        ibus_inta = 1'b0;
        tick;
        expv(8'h00); expv(8'h00); expv(8'h50); expv(8'h00);
        chk_rd("pend_post_rst", 2'd0);
        chk_rd("mask_post_rst", 2'd1);
        chk_rd("vbase_post_rst", 2'd2);
        chk_rd("isvc_post_rst", 2'd3);

        // higher-priority source while a lower one is in service
        wr(2'd1, 8'h05);
        wr(2'd2, 8'h40);
        expv(8'h00); expv(8'h44);
        pulse(4'b0100);
        tick; tick; tick;
        chk("int_n_low_src", 8'(int_n));
        ibus_inta = 1'b1;
        tick;
        chk("vec_low_src", obus_dslave);
        ibus_inta = 1'b0;
        tick;
        pulse(4'b0001);
        tick; tick; tick;
`ifdef INTC_NEST_EN
        expv(8'h00); expv(8'h40); expv(8'h05); expv(8'h04); expv(8'h00);
        chk("int_n_preempt", 8'(int_n));
        ibus_inta = 1'b1;
        tick;
        chk("vec_preempt", obus_dslave);
        ibus_inta = 1'b0;
        tick;
        chk_rd("isvc_stack", 2'd3);
        wr(2'd3, 8'h00);
        chk_rd("isvc_eoi1", 2'd3);
        wr(2'd3, 8'h00);
        chk_rd("isvc_eoi2", 2'd3);
`else
        expv(8'h01); expv(8'h01); expv(8'h00); expv(8'h40); expv(8'h01);
        chk("int_n_no_preempt", 8'(int_n));
        chk_rd("isvc_single", 2'd3);
        wr(2'd3, 8'h00);
        chk("int_n_after_eoi2", 8'(int_n));
        ibus_inta = 1'b1;
        tick;
        chk("vec_after_eoi", obus_dslave);
        ibus_inta = 1'b0;
        tick;
        chk_rd("isvc_reacked", 2'd3);
`endif

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_drain left=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
